// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle RISC-V core: captures a load/store request,
// waits WAIT cycles, commits or reads one 32-bit word and returns a one-cycle ready pulse.
module data_mem_responder #(
    parameter int          DEPTH     = 64,
    parameter int          WAIT      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        busy
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        err_reg;
    logic        capture;
    logic        enter_resp;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    // With WAIT=0 the commit edge is also the accept edge, so the live inputs must be used.
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic [31:0] offset;
    logic        addr_err;
    logic [IDX_W-1:0] sel_idx;

    assign sel_we    = (state_reg == ST_IDLE) ? mem_we    : we_reg;
    assign sel_addr  = (state_reg == ST_IDLE) ? mem_addr  : addr_reg;
    assign sel_wdata = (state_reg == ST_IDLE) ? mem_wdata : wdata_reg;
    assign sel_be    = (state_reg == ST_IDLE) ? mem_be    : be_reg;

    // An address below BASE_ADDR wraps to a huge offset, so the range test alone catches it.
    assign offset   = sel_addr - BASE_ADDR;
    assign addr_err = (sel_addr[1:0] != 2'b00) || ((offset >> 2) >= 32'(DEPTH));
    assign sel_idx  = offset[IDX_W+1:2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_req) begin
                    capture = 1'b1;
                    if (WAIT == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            be_reg    <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                we_reg    <= mem_we;
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
                be_reg    <= mem_be;
            end
            if (enter_resp)
                err_reg <= addr_err;
            else if (state_reg == ST_RESP)
                err_reg <= 1'b0;
        end
    end

    // Memory is never reset; writes are gated so nothing commits while reset is held.
    always_ff @(posedge clk) begin
        if (enter_resp && reset && !addr_err) begin
            if (sel_we) begin
                for (int b = 0; b < 4; b++)
                    if (sel_be[b])
                        mem[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end else begin
                rd_word <= mem[sel_idx];
            end
        end
    end

    assign mem_ready = (state_reg == ST_RESP);
    assign mem_err   = mem_ready && err_reg;
    assign mem_rdata = (mem_ready && !err_reg && !we_reg) ? rd_word : 32'd0;
    assign busy      = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
    localparam int          DEPTH_C = 64;
    localparam int          WAIT_C  = 2;
    localparam logic [31:0] BASE_C  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        busy;

    int total_cnt  = 0;
    int passed_cnt = 0;

    logic [31:0] model_mem [DEPTH_C];

    data_mem_responder #(.DEPTH(DEPTH_C), .WAIT(WAIT_C), .BASE_ADDR(BASE_C)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit model_err(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE_C);
        if (a[1:0] != 2'b00) return 1'b1;
        if (off < 0) return 1'b1;
        if ((off / 4) >= longint'(DEPTH_C)) return 1'b1;
        return 1'b0;
    endfunction

    // Presents one request at a negedge and follows it to its response. acc_edges is the
    // number of rising edges until acceptance (2 when issued during the previous RESP).
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int acc_edges, input bit chain,
                       output logic [31:0] rdata);
        int edges;
        int lat;
        bit exp_err;
        int idx;
        logic [31:0] exp_rd;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_be = be;
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (!busy && edges < 10);
        total_cnt++;
        if (edges !== acc_edges)
            $display("FAIL accept_delay addr=%h: got %0d edges, expected %0d", addr, edges, acc_edges);
        else passed_cnt++;
        // Garbage on the inputs while the transaction is in flight must be ignored.
        mem_req = 1'($urandom); mem_we = 1'($urandom); mem_addr = $urandom;
        mem_wdata = $urandom; mem_be = 4'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (mem_ready) break;
            total_cnt++;
            if (mem_rdata !== 32'd0 || mem_err !== 1'b0 || busy !== 1'b1)
                $display("FAIL wait_outputs addr=%h: rdata=%h err=%b busy=%b, expected 0/0/1",
                         addr, mem_rdata, mem_err, busy);
            else passed_cnt++;
            mem_req = 1'($urandom); mem_addr = $urandom;
        end
        exp_err = model_err(addr);
        idx = int'((addr - BASE_C) >> 2);
        exp_rd = (!we && !exp_err) ? model_mem[idx] : 32'd0;
        total_cnt++;
        if (lat !== WAIT_C + 1)
            $display("FAIL latency addr=%h: got %0d cycles, expected %0d", addr, lat, WAIT_C + 1);
        else passed_cnt++;
        total_cnt++;
        if (mem_err !== exp_err)
            $display("FAIL err addr=%h: got %b, expected %b", addr, mem_err, exp_err);
        else passed_cnt++;
        total_cnt++;
        if (mem_rdata !== exp_rd)
            $display("FAIL rdata addr=%h: got %h, expected %h", addr, mem_rdata, exp_rd);
        else passed_cnt++;
        rdata = mem_rdata;
        $display("txn %s addr=%h wdata=%h be=%h -> rdata=%h err=%b lat=%0d",
                 we ? "ST" : "LD", addr, wdata, be, mem_rdata, mem_err, lat);
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        mem_req = 1'b0;
        if (!chain) begin
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b0 || mem_ready !== 1'b0 || mem_rdata !== 32'd0 || mem_err !== 1'b0)
                $display("FAIL after_resp addr=%h: busy=%b ready=%b rdata=%h err=%b, expected all 0",
                         addr, busy, mem_ready, mem_rdata, mem_err);
            else passed_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_be = 4'd0;
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if (mem_ready !== 1'b0 || mem_rdata !== 32'd0 || mem_err !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_hold: ready=%b rdata=%h err=%b busy=%b, expected all 0",
                         mem_ready, mem_rdata, mem_err, busy);
            else passed_cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'd0 || mem_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release: ready=%b rdata=%h err=%b busy=%b, expected all 0",
                     mem_ready, mem_rdata, mem_err, busy);
        else passed_cnt++;
    endtask

    task automatic test_fill();
        logic [31:0] r;
        for (int i = 0; i < DEPTH_C; i++)
            txn(1'b1, BASE_C + 32'(i * 4), $urandom, 4'hF, 1, 1'b0, r);
    endtask

    task automatic test_store_load();
        logic [31:0] r;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0, r);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'hDEADBEEF) $display("FAIL store_load: got %h, expected deadbeef", r);
        else passed_cnt++;
    endtask

    task automatic test_byte_enables();
        logic [31:0] r;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 1'b0, r);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 1'b0, r);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'h11BB33DD) $display("FAIL byte_enable: got %h, expected 11bb33dd", r);
        else passed_cnt++;
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1, 1'b0, r);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'h11BB33DD) $display("FAIL be_zero: got %h, expected 11bb33dd", r);
        else passed_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] r;
        txn(1'b0, 32'h13, 32'd0, 4'h0, 1, 1'b0, r);
        txn(1'b1, 32'h100, 32'h55555555, 4'hF, 1, 1'b0, r);
        txn(1'b0, 32'hFC, 32'd0, 4'h0, 1, 1'b0, r);
        txn(1'b1, 32'hFFFFFFFC, 32'h66666666, 4'hF, 1, 1'b0, r);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'hDEADBEEF) $display("FAIL err_no_side_effect: got %h, expected deadbeef", r);
        else passed_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        for (int i = 0; i < 6; i++)
            txn(1'($urandom), BASE_C + 32'($urandom_range(0, DEPTH_C - 1) * 4), $urandom,
                4'($urandom), (i == 0) ? 1 : 2, (i != 5), r);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        txn(1'b1, 32'h8, 32'h7, 4'hF, 1, 1'b0, r);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h5; mem_be = 4'hF;
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || mem_ready !== 1'b0)
            $display("FAIL reset_in_wait: busy=%b ready=%b, expected 0/0", busy, mem_ready);
        else passed_cnt++;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if (mem_ready !== 1'b0) $display("FAIL reset_no_ready: ready=%b, expected 0", mem_ready);
            else passed_cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h8, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'h7) $display("FAIL reset_abandon: got %h, expected 00000007", r);
        else passed_cnt++;
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] r;
        int n;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h12345678; mem_be = 4'hF;
        @(posedge clk); #1;
        mem_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_ready && n < 20);
        total_cnt++;
        if (mem_ready !== 1'b1) $display("FAIL resp_reached: ready=%b, expected 1", mem_ready);
        else passed_cnt++;
        model_mem[12] = 32'h12345678;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (mem_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_in_resp: ready=%b busy=%b, expected 0/0", mem_ready, busy);
        else passed_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h30, 32'd0, 4'h0, 1, 1'b0, r);
        total_cnt++;
        if (r !== 32'h12345678) $display("FAIL commit_survives: got %h, expected 12345678", r);
        else passed_cnt++;
    endtask

    task automatic test_counting_sort();
        int arr[20]    = '{3, 7, 2, 6, 5, 4, 1, 1000, 999, 25, 90, 100, 30, 20, 10, 200, 3300, 250, 12, 75};
        int cnt[20]    = '{17, 13, 18, 14, 15, 16, 19, 1, 2, 9, 6, 5, 8, 10, 12, 4, 0, 3, 11, 7};
        int sorted[20] = '{3300, 1000, 999, 250, 200, 100, 90, 75, 30, 25, 20, 12, 10, 7, 6, 5, 4, 3, 2, 1};
        logic [31:0] r;
        for (int i = 0; i < 20; i++)
            txn(1'b1, BASE_C + 32'(cnt[i] * 4), 32'(arr[i]), 4'hF, 1, 1'b0, r);
        for (int i = 0; i < 20; i++) begin
            txn(1'b0, BASE_C + 32'(i * 4), 32'd0, 4'h0, 1, 1'b0, r);
            total_cnt++;
            if (r !== 32'(sorted[i]))
                $display("FAIL sort_word%0d: got %0d, expected %0d", i, r, sorted[i]);
            else passed_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = BASE_C + 32'($urandom_range(0, DEPTH_C - 1) * 4);
                2:    a = BASE_C + 32'($urandom_range(0, DEPTH_C * 4 - 1));
                default: a = $urandom;
            endcase
            txn(1'($urandom), a, $urandom, 4'($urandom), 1, 1'b0, r);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_reset_in_resp();
        test_counting_sort();
        test_random();
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end
endmodule
